// File: rtl/tdm.sv
// Four-channel round-robin time-division multiplexer: a free-running 2-bit
// slot counter steers one of four inputs onto a shared combinational output.
module tdm #(
    parameter int unsigned DATA_W = 2
) (
    input  logic [DATA_W-1:0] in0,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    input  logic [DATA_W-1:0] in3,
    input  logic              rst,
    input  logic              clk,
    output logic [DATA_W-1:0] out
);

    localparam int unsigned SLOT_W = 2;

    logic [SLOT_W-1:0] counter_q;
    logic [SLOT_W-1:0] counter_d;
    logic [SLOT_W-1:0] counter_out;

    // Natural 2-bit wrap gives 3 -> 0 with no idle slot.
    always_comb begin
        counter_d = SLOT_W'(counter_q + SLOT_W'(1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            counter_q <= '0;
        end else begin
            counter_q <= counter_d;
        end
    end

    assign counter_out = counter_q;

    // Fully decoded select; the output is intentionally unregistered.
    always_comb begin
        out = in0;
        unique case (counter_out)
            2'd0: out = in0;
            2'd1: out = in1;
            2'd2: out = in2;
            2'd3: out = in3;
        endcase
    end

endmodule

// File: tb/tb_tdm.sv
// Randomized self-checking bench for tdm against a slot-index reference model.
`timescale 1ns/1ps
module tb_tdm;

    logic       clk;
    logic       rst;
    logic [1:0] ch  [4];
    logic [7:0] wch [4];
    logic [1:0] out;
    logic [7:0] wout;

    int checks;
    int failures;
    int slot_m;

    tdm DUT (
        .in0 (ch[0]),
        .in1 (ch[1]),
        .in2 (ch[2]),
        .in3 (ch[3]),
        .rst (rst),
        .clk (clk),
        .out (out)
    );

    tdm #(.DATA_W(8)) dut_w8 (
        .in0 (wch[0]),
        .in1 (wch[1]),
        .in2 (wch[2]),
        .in3 (wch[3]),
        .rst (rst),
        .clk (clk),
        .out (wout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: slot = rising edges seen with reset released since last reset, mod 4.
    task automatic step();
        @(posedge clk);
        if (rst) slot_m = (slot_m + 1) % 4;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ch[0] = 2'b00; ch[1] = 2'b01; ch[2] = 2'b10; ch[3] = 2'b11;
        slot_m = 0;
        @(negedge clk);
        checks++;
        if (DUT.counter_out !== 2'd0) begin
            failures++;
            $display("FAIL reset_counter got=%0d want=0", DUT.counter_out);
        end
        checks++;
        if (out !== 2'b00) begin
            failures++;
            $display("FAIL reset_out got=%b want=00", out);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_cnt [8];
        logic [1:0] exp_out [8];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_out = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (DUT.counter_out !== exp_cnt[i]) begin
                failures++;
                $display("FAIL rr_counter[%0d] got=%0d want=%0d", i, DUT.counter_out, exp_cnt[i]);
            end
            checks++;
            if (out !== exp_out[i]) begin
                failures++;
                $display("FAIL rr_out[%0d] got=%b want=%b", i, out, exp_out[i]);
            end
            checks++;
            if (out !== ch[slot_m]) begin
                failures++;
                $display("FAIL rr_model[%0d] got=%b want=%b", i, out, ch[slot_m]);
            end
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 4 && slot_m != 3; i++) step();
        checks++;
        if (DUT.counter_out !== 2'd3) begin
            failures++;
            $display("FAIL wrap_pre got=%0d want=3", DUT.counter_out);
        end
        step();
        checks++;
        if (DUT.counter_out !== 2'd0 || out !== ch[0]) begin
            failures++;
            $display("FAIL wrap_post got cnt=%0d out=%b want cnt=0 out=%b",
                     DUT.counter_out, out, ch[0]);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4 && slot_m != 2; i++) step();
        checks++;
        if (DUT.counter_out !== 2'd2) begin
            failures++;
            $display("FAIL async_pre got=%0d want=2", DUT.counter_out);
        end
        #1 rst = 1'b0;
        slot_m = 0;
        #1;
        checks++;
        if (DUT.counter_out !== 2'd0 || out !== ch[0]) begin
            failures++;
            $display("FAIL async_assert got cnt=%0d out=%b want cnt=0 out=%b",
                     DUT.counter_out, out, ch[0]);
        end
        step();
        checks++;
        if (DUT.counter_out !== 2'd0) begin
            failures++;
            $display("FAIL async_hold got=%0d want=0", DUT.counter_out);
        end
        rst = 1'b1;
        step();
        checks++;
        if (DUT.counter_out !== 2'd1 || out !== ch[1]) begin
            failures++;
            $display("FAIL async_release got cnt=%0d out=%b want cnt=1 out=%b",
                     DUT.counter_out, out, ch[1]);
        end
    endtask

    task automatic test_comb_path();
        for (int i = 0; i < 4 && slot_m != 1; i++) step();
        ch[1] = 2'b01;
        #1;
        checks++;
        if (out !== 2'b01) begin
            failures++;
            $display("FAIL comb_before got=%b want=01", out);
        end
        #1 ch[1] = 2'b10;
        #1;
        checks++;
        if (out !== 2'b10 || DUT.counter_out !== 2'd1) begin
            failures++;
            $display("FAIL comb_follow got out=%b cnt=%0d want out=10 cnt=1",
                     out, DUT.counter_out);
        end
        ch[1] = 2'b01;
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            for (int k = 0; k < 4; k++) ch[k] = 2'($urandom);
            #1;
            checks++;
            if (DUT.counter_out !== 2'(slot_m) || out !== ch[slot_m]) begin
                failures++;
                $display("FAIL rand[%0d] got cnt=%0d out=%b want cnt=%0d out=%b",
                         n, DUT.counter_out, out, slot_m, ch[slot_m]);
            end
            if ($urandom_range(0, 9) == 0) begin
                rst = 1'b0;
                slot_m = 0;
                #1;
                checks++;
                if (DUT.counter_out !== 2'd0 || out !== ch[0]) begin
                    failures++;
                    $display("FAIL rand_rst[%0d] got cnt=%0d out=%b want cnt=0 out=%b",
                             n, DUT.counter_out, out, ch[0]);
                end
                #1 rst = 1'b1;
            end
            step();
        end
    endtask

    task automatic test_param_w8();
        logic [7:0] exp_w [4];
        exp_w = '{8'h22, 8'h33, 8'h44, 8'h11};
        wch[0] = 8'h11; wch[1] = 8'h22; wch[2] = 8'h33; wch[3] = 8'h44;
        rst = 1'b0;
        slot_m = 0;
        #1;
        checks++;
        if (wout !== 8'h11 || dut_w8.counter_out !== 2'd0) begin
            failures++;
            $display("FAIL w8_reset got out=%h cnt=%0d want out=11 cnt=0",
                     wout, dut_w8.counter_out);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (wout !== exp_w[i % 4] || wout !== wch[slot_m]) begin
                failures++;
                $display("FAIL w8_seq[%0d] got=%h want=%h", i, wout, exp_w[i % 4]);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        slot_m   = 0;
        rst      = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ch[k]  = '0;
            wch[k] = '0;
        end
        test_reset();
        test_round_robin();
        test_wrap();
        test_async_reset();
        test_comb_path();
        test_random();
        test_param_w8();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
